uart_tx_scheduler: RTL and testbench

- Owns the tx_uart instance's write and config ports.
- On reset release it issues one baud-config write. It then shares the transmitter between NUM_REQ byte requesters using round-robin arbitration.
- tx_uart has no busy output, so the block enforces a minimum spacing of CHAR_CYCLES clocks between successive write_enable pulses.
- Sits between the ROM/CPU-side byte producers and tx_uart, replacing hand-written counter sequencing in top-level test designs.

---
 rtl/uart_tx_scheduler_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_pkg
// Purpose  : Shared definitions for the tx_uart scheduler. This package
//            contains the scheduler state encodings, the 115200-baud config
//            byte that is also used by the tx_uart tests, and a helper that
//            sizes requester index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    // Scheduler states, shared by the scheduler and anything that decodes them.
    typedef enum logic [2:0] {
        BOOT_CFG_S = 3'd0,
        CFG_END    = 3'd1,
        IDLE       = 3'd2,
        WRITE      = 3'd3,
        WAIT       = 3'd4
    } sched_state_t;

    // tx_uart config byte that selects 115200 baud.
    localparam logic [7:0] c_CFG_115200 = 8'b0000_1011;

    // Width of an index into n requesters. A single requester still needs a
    // one-bit field, because a zero-width vector cannot be declared.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. The search for an asserted
//            request starts at last+1 and wraps around cyclically.
// Ports    : req       [N]        request vector
//            last      [IW]       index of the previous grant
//            gnt_valid            at least one request is asserted
//            gnt_idx   [IW]       index of the granted request
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]               req,
    input  logic [idx_width(N)-1:0]    last,
    output logic                       gnt_valid,
    output logic [idx_width(N)-1:0]    gnt_idx
);

    localparam int c_IW = idx_width(N);

    int unsigned w_idx;

    // The loop runs from the farthest offset down to the nearest one. The
    // nearest asserted request writes last, so it wins the grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        for (int off = N; off >= 1; off--) begin
            w_idx = 32'((int'(last) + off) % N);
            if (|(req & (N'(1) << w_idx))) begin
                gnt_valid = 1'b1;
                gnt_idx   = c_IW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Drives the write and config ports of tx_uart.
//            - After reset it writes the boot config byte once.
//            - It then shares the transmitter between NUM_REQ byte
//              requesters using round-robin order.
//            - A config request has priority over data requests.
//            - Because tx_uart has no busy output, successive write_enable
//              pulses are spaced CHAR_CYCLES clocks apart.
// Ports    : clk            system clock (rising edge)
//            rst            asynchronous active-low reset
//            req_valid/data/ready   per-requester byte handshake
//            cfg_valid/data/ready   runtime config handshake
//            busy           high whenever the scheduler is not idle
//            write_data/enable, config_data/enable   to tx_uart
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter int          CHAR_CYCLES = 875,
    parameter logic [7:0]  BOOT_CFG    = c_CFG_115200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    cfg_valid,
    input  logic [7:0]              cfg_data,
    output logic                    cfg_ready,
    output logic                    busy,
    output logic [7:0]              write_data,
    output logic                    write_enable,
    output logic [7:0]              config_data,
    output logic                    config_enable
);

    localparam int c_IW    = idx_width(NUM_REQ);
    localparam int c_CNT_W = $clog2(CHAR_CYCLES);
    // Decision in IDLE, the WRITE cycle, and the WAIT cycle that sees zero
    // together account for the three clocks not covered by the count.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(CHAR_CYCLES - 3);

    sched_state_t          r_state,         w_state_nxt;
    logic [c_IW-1:0]       r_rr_last,       w_rr_last_nxt;
    logic [c_CNT_W-1:0]    r_count,         w_count_nxt;
    logic [7:0]            r_write_data,    w_write_data_nxt;
    logic                  r_write_enable,  w_write_enable_nxt;
    logic [NUM_REQ-1:0]    r_req_ready,     w_req_ready_nxt;
    logic                  r_cfg_ready,     w_cfg_ready_nxt;
    logic [7:0]            r_config_data,   w_config_data_nxt;
    logic                  r_config_enable, w_config_enable_nxt;

    logic                  w_gnt_valid;
    logic [c_IW-1:0]       w_gnt_idx;
    logic [7:0]            w_gnt_data;

    rr_arbiter #(
        .N         (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (r_rr_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_gnt_data = 8'(req_data >> {w_gnt_idx, 3'b000});

    // The pulse outputs are registered. They are computed in the same cycle
    // as the transition into the state where they must be visible.
    always_comb begin
        w_state_nxt         = r_state;
        w_rr_last_nxt       = r_rr_last;
        w_count_nxt         = r_count;
        w_write_data_nxt    = r_write_data;
        w_write_enable_nxt  = 1'b0;
        w_req_ready_nxt     = '0;
        w_cfg_ready_nxt     = 1'b0;
        w_config_data_nxt   = r_config_data;
        w_config_enable_nxt = 1'b0;

        unique case (r_state)
            BOOT_CFG_S: begin
                w_config_data_nxt   = BOOT_CFG;
                w_config_enable_nxt = 1'b1;
                w_state_nxt         = CFG_END;
            end
            CFG_END: begin
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (cfg_valid) begin
                    w_config_data_nxt   = cfg_data;
                    w_config_enable_nxt = 1'b1;
                    w_cfg_ready_nxt     = 1'b1;
                    w_state_nxt         = CFG_END;
                end else if (w_gnt_valid) begin
                    w_req_ready_nxt    = NUM_REQ'(1) << w_gnt_idx;
                    w_write_data_nxt   = w_gnt_data;
                    w_write_enable_nxt = 1'b1;
                    w_rr_last_nxt      = w_gnt_idx;
                    w_state_nxt        = WRITE;
                end
            end
            WRITE: begin
                w_count_nxt = c_CNT_LOAD;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_count == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_count_nxt = r_count - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= BOOT_CFG_S;
            r_rr_last       <= c_IW'(NUM_REQ - 1);
            r_count         <= '0;
            r_write_data    <= '0;
            r_write_enable  <= 1'b0;
            r_req_ready     <= '0;
            r_cfg_ready     <= 1'b0;
            r_config_data   <= '0;
            r_config_enable <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rr_last       <= w_rr_last_nxt;
            r_count         <= w_count_nxt;
            r_write_data    <= w_write_data_nxt;
            r_write_enable  <= w_write_enable_nxt;
            r_req_ready     <= w_req_ready_nxt;
            r_cfg_ready     <= w_cfg_ready_nxt;
            r_config_data   <= w_config_data_nxt;
            r_config_enable <= w_config_enable_nxt;
        end
    end

    assign busy          = (r_state != IDLE);
    assign write_data    = r_write_data;
    assign write_enable  = r_write_enable;
    assign req_ready     = r_req_ready;
    assign cfg_ready     = r_cfg_ready;
    assign config_data   = r_config_data;
    assign config_enable = r_config_enable;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler.
//            - Stimulus is a set of directed scenarios followed by a
//              randomized phase.
//            - Expected outputs come from a transaction-timing model. The
//              model tracks the clock on which the scheduler next makes a
//              decision, the round-robin pointer, and the values of the
//              pulses it should emit.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int         NUM_REQ     = 2;
    localparam int         CHAR_CYCLES = 8;
    localparam logic [7:0] BOOT_CFG    = 8'h0B;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [8*NUM_REQ-1:0]  req_data  = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  cfg_valid = 1'b0;
    logic [7:0]            cfg_data  = '0;
    logic                  cfg_ready;
    logic                  busy;
    logic [7:0]            write_data;
    logic                  write_enable;
    logic [7:0]            config_data;
    logic                  config_enable;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .CHAR_CYCLES   (CHAR_CYCLES),
        .BOOT_CFG      (BOOT_CFG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .busy          (busy),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .config_data   (config_data),
        .config_enable (config_enable)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int                 k;            // clock edges since reset release
    int                 free_at;      // edge at which the next decision is made
    int                 rr_last;
    bit                 boot_pending;
    logic               exp_we, exp_ce, exp_cr, exp_busy;
    logic [7:0]         exp_wd, exp_cd;
    logic [NUM_REQ-1:0] exp_rr;

    bit rnd_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=0x%0h expected=0x%0h", tag, k, act, exp);
        end
    endtask

    task automatic model_reset();
        k            = 0;
        free_at      = 0;
        rr_last      = NUM_REQ - 1;
        boot_pending = 1'b1;
        exp_we       = 1'b0;
        exp_ce       = 1'b0;
        exp_cr       = 1'b0;
        exp_wd       = 8'h00;
        exp_cd       = 8'h00;
        exp_rr       = '0;
        exp_busy     = 1'b1;
    endtask

    // One rising edge with reset released, evaluated on the inputs present
    // at that edge.
    task automatic model_step();
        int  g;
        bit  found;
        exp_we = 1'b0;
        exp_ce = 1'b0;
        exp_cr = 1'b0;
        exp_rr = '0;
        if (boot_pending) begin
            exp_ce       = 1'b1;
            exp_cd       = BOOT_CFG;
            boot_pending = 1'b0;
            free_at      = k + 2;
        end else if (k >= free_at) begin
            if (cfg_valid) begin
                exp_ce  = 1'b1;
                exp_cr  = 1'b1;
                exp_cd  = cfg_data;
                free_at = k + 2;
            end else begin
                found = 1'b0;
                g     = 0;
                for (int off = 1; off <= NUM_REQ && !found; off++) begin
                    g = (rr_last + off) % NUM_REQ;
                    if (req_valid[g]) found = 1'b1;
                end
                if (found) begin
                    exp_we    = 1'b1;
                    exp_wd    = req_data[8*g +: 8];
                    exp_rr[g] = 1'b1;
                    rr_last   = g;
                    free_at   = k + CHAR_CYCLES;
                end else begin
                    free_at = k + 1;
                end
            end
        end
        exp_busy = (free_at > k + 1);
        k++;
    endtask

    task automatic check_outputs();
        check("write_enable",  write_enable,  exp_we);
        check("write_data",    write_data,    exp_wd);
        check("config_enable", config_enable, exp_ce);
        check("config_data",   config_data,   exp_cd);
        check("req_ready",     req_ready,     exp_rr);
        check("cfg_ready",     cfg_ready,     exp_cr);
        check("busy",          busy,          exp_busy);
    endtask

    // Requester and config-source behaviour, applied at the falling edge
    // after the outputs have been checked.
    task automatic drive();
        if (cfg_ready) begin
            cfg_valid = 1'b0;
        end else if (rnd_mode && !cfg_valid && ($urandom % 50 == 0)) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
        end
        if (rnd_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    req_valid[i]        = 1'($urandom % 2);
                    req_data[8*i +: 8]  = 8'($urandom);
                end else if (!req_valid[i]) begin
                    if ($urandom % 4 == 0) begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom % 40 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check_outputs();
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        while (!write_enable && n < 40) begin
            tick();
            n++;
        end
        if (!write_enable) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset(3);

        // Boot config after reset release, with no requests pending.
        repeat (6) tick();

        // A single continuous requester.
        req_data[7:0] = 8'h41;
        req_valid[0]  = 1'b1;
        repeat (30) tick();
        req_valid = '0;
        repeat (10) tick();

        // Both requesters continuously valid from reset; grants alternate.
        do_reset(2);
        req_data     = {8'h42, 8'h41};
        req_valid    = 2'b11;
        repeat (40) tick();
        req_valid = '0;
        repeat (10) tick();

        // Config and data requests arrive together while idle.
        cfg_data     = 8'h07;
        cfg_valid    = 1'b1;
        req_valid[1] = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        repeat (10) tick();

        // Reset during WAIT, three cycles after a write.
        req_valid[1] = 1'b1;
        wait_write("timeout_write_before_reset");
        repeat (3) tick();
        do_reset(2);
        repeat (20) tick();
        req_valid = '0;
        repeat (10) tick();

        // A short pulse on requester 1 during WAIT must not be granted.
        req_valid[0] = 1'b1;
        wait_write("timeout_write_before_pulse");
        req_valid[0] = 1'b0;
        tick();
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        repeat (12) tick();

        // Randomized traffic with occasional resets.
        rnd_mode = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom % 300 == 0) begin
                do_reset(1 + int'($urandom % 3));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
